// File: rtl/gfx_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : gfx_framebuffer_writer
// Description : Single-port framebuffer write engine. Converts (x, y, colour)
//               pixel writes into linear SRAM addresses, arbitrates for the
//               SRAM bus with video scan-out and runs a timed write cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_framebuffer_writer #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    parameter int WRITE_PULSE   = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        writeRequest_i,
    input  logic [8:0]  pixelX_i,
    input  logic [7:0]  pixelY_i,
    input  logic [7:0]  pixelData_i,
    output logic        writeComplete_o,
    output logic        outOfRange_o,
    output logic        busRequest_o,
    input  logic        busGrant_i,
    output logic [16:0] sramAddress_o,
    output logic [7:0]  sramWriteData_o,
    output logic        sramDataDrive_o,
    output logic        sramWriteEnable_n_o
);

    localparam logic [8:0] c_WIDTH    = 9'(SCREEN_WIDTH);
    localparam logic [7:0] c_HEIGHT   = 8'(SCREEN_HEIGHT);
    localparam logic [3:0] c_PULSE_M1 = 4'(WRITE_PULSE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        busReq_q, busReq_d;
    logic        oor_q, oor_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic        w_inRange;
    logic [16:0] w_linearAddr;

    // Coordinate to linear address; a constant stride folds into shift-adds.
    assign w_inRange    = (pixelX_i < c_WIDTH) && (pixelY_i < c_HEIGHT);
    assign w_linearAddr = 17'(pixelY_i) * 17'(SCREEN_WIDTH) + 17'(pixelX_i);

    // State and datapath registers; reset aborts any write in flight.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            count_q  <= 4'd0;
            busReq_q <= 1'b0;
            oor_q    <= 1'b0;
            addr_q   <= 17'd0;
            data_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busReq_q <= busReq_d;
            oor_q    <= oor_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Next-state logic: request/grant in IDLE, then a fixed setup/strobe/hold.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busReq_d = busReq_q;
        oor_d    = oor_q;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                busReq_d = writeRequest_i & w_inRange;
                if (writeRequest_i && !w_inRange) begin
                    // Rejected without touching the bus.
                    oor_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (writeRequest_i && busGrant_i && busReq_q) begin
                    addr_d  = w_linearAddr;
                    data_d  = pixelData_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                busReq_d = 1'b1;
                count_d  = c_PULSE_M1;
                state_d  = ST_STROBE;
            end
            ST_STROBE: begin
                busReq_d = 1'b1;
                if (count_q == 4'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ST_HOLD: begin
                // Bus is released as HOLD ends.
                busReq_d = 1'b0;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                busReq_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                busReq_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // SRAM strobes decode straight from the state register, so an
    // asynchronous reset releases them immediately.
    assign sramWriteEnable_n_o = (state_q != ST_STROBE);
    assign sramDataDrive_o     = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                                 (state_q == ST_HOLD);
    assign writeComplete_o     = (state_q == ST_DONE);
    assign outOfRange_o        = oor_q;
    assign busRequest_o        = busReq_q;
    assign sramAddress_o       = addr_q;
    assign sramWriteData_o     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_framebuffer_writer
// Description : Self-checking bench for gfx_framebuffer_writer. Expected SRAM
//               writes are queued as requests are issued and popped on each
//               strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_framebuffer_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req;
    logic [8:0]  px;
    logic [7:0]  py;
    logic [7:0]  pd;
    logic        grant;
    logic        cpl, oor, breq, drv, wen;
    logic [16:0] addr;
    logic [7:0]  wdata;

    logic        req_a, req_b, g_one;
    logic [8:0]  px_s;
    logic [7:0]  py_s, pd_s;
    logic        cpl_a, oor_a, breq_a, drv_a, wen_a;
    logic        cpl_b, oor_b, breq_b, drv_b, wen_b;
    logic [16:0] addr_a, addr_b;
    logic [7:0]  wd_a, wd_b;

    gfx_framebuffer_writer #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240), .WRITE_PULSE(2)) u_dut (
        .clock_i(clk), .reset_i(rst), .writeRequest_i(req),
        .pixelX_i(px), .pixelY_i(py), .pixelData_i(pd),
        .writeComplete_o(cpl), .outOfRange_o(oor), .busRequest_o(breq),
        .busGrant_i(grant), .sramAddress_o(addr), .sramWriteData_o(wdata),
        .sramDataDrive_o(drv), .sramWriteEnable_n_o(wen)
    );

    gfx_framebuffer_writer #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240), .WRITE_PULSE(1)) u_dut_p1 (
        .clock_i(clk), .reset_i(rst), .writeRequest_i(req_a),
        .pixelX_i(px_s), .pixelY_i(py_s), .pixelData_i(pd_s),
        .writeComplete_o(cpl_a), .outOfRange_o(oor_a), .busRequest_o(breq_a),
        .busGrant_i(g_one), .sramAddress_o(addr_a), .sramWriteData_o(wd_a),
        .sramDataDrive_o(drv_a), .sramWriteEnable_n_o(wen_a)
    );

    gfx_framebuffer_writer #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240), .WRITE_PULSE(15)) u_dut_p15 (
        .clock_i(clk), .reset_i(rst), .writeRequest_i(req_b),
        .pixelX_i(px_s), .pixelY_i(py_s), .pixelData_i(pd_s),
        .writeComplete_o(cpl_b), .outOfRange_o(oor_b), .busRequest_o(breq_b),
        .busGrant_i(g_one), .sramAddress_o(addr_b), .sramWriteData_o(wd_b),
        .sramDataDrive_o(drv_b), .sramWriteEnable_n_o(wen_b)
    );

    typedef struct packed {
        logic [16:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   n_cpl  = 0;
    logic prev_wen = 1'b1;
    logic prev_cpl = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe start pops one expected write; completes counted.
    always @(negedge clk) begin
        if (rst) begin
            prev_wen = 1'b1;
            prev_cpl = 1'b0;
        end else begin
            if (!wen && prev_wen) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e_mon = sb.pop_front();
                    check("sram_addr", 32'(addr), 32'(e_mon.a));
                    check("sram_data", 32'(wdata), 32'(e_mon.d));
                end
            end
            if (cpl) begin
                n_cpl++;
                check("cpl_one_cycle", 32'(prev_cpl), 0);
            end
            prev_wen = wen;
            prev_cpl = cpl;
        end
    end

    // Issue one request on the main DUT and wait for its completion.
    // lat counts cycles from the cycle the request rises to the DONE cycle.
    task automatic do_write(input int x, input int y, input int d, input int gdelay,
                            input bit drop_in_strobe, output int lat, output int strobe);
        int   n;
        bit   dropped;
        exp_t e;
        n = 0; strobe = 0; dropped = 0; lat = -1;
        @(posedge clk); #1;
        px = 9'(x); py = 8'(y); pd = 8'(d); req = 1'b1;
        if (x < 320 && y < 240) begin
            e.a = 17'(y * 320 + x);
            e.d = 8'(d);
            sb.push_back(e);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (gdelay > 0 && n >= 2 && n <= gdelay) begin
                check("busreq_wait", 32'(breq), 1);
                check("no_strobe_wait", 32'(wen), 1);
            end
            if (gdelay > 0 && n == gdelay) grant = 1'b1;
            if (!wen) begin
                strobe++;
                if (drop_in_strobe) begin
                    grant = 1'b0;
                    dropped = 1;
                end
            end
            if (cpl) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) check("write_timeout", 1, 0);
        if (dropped) grant = 1'b1;
    endtask

    task automatic drop_req();
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // One write on a sweep instance (which=0: WRITE_PULSE 1, which=1: 15).
    task automatic sweep_write(input bit which, output int lat, output int strobe);
        int n;
        n = 0; strobe = 0; lat = -1;
        @(posedge clk); #1;
        px_s = 9'd7; py_s = 8'd3; pd_s = 8'h5A;
        if (which) req_b = 1'b1; else req_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (!(which ? wen_b : wen_a)) strobe++;
            if (which ? cpl_b : cpl_a) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) check("sweep_timeout", 1, 0);
        check("sweep_addr", 32'(which ? addr_b : addr_a), 967);
        check("sweep_data", 32'(which ? wd_b : wd_a), 32'h5A);
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    // Stimulus sequence.
    initial begin
        int lat, st, c0;
        rst = 1'b1; req = 1'b0; grant = 1'b0;
        px = '0; py = '0; pd = '0;
        req_a = 1'b0; req_b = 1'b0; g_one = 1'b1;
        px_s = '0; py_s = '0; pd_s = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cpl", 32'(cpl), 0);
        check("rst_oor", 32'(oor), 0);
        check("rst_breq", 32'(breq), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_drv", 32'(drv), 0);
        check("rst_wen", 32'(wen), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_cpl", 32'(cpl), 0);
        check("idle_breq", 32'(breq), 0);
        check("idle_wen", 32'(wen), 1);
        check("idle_drv", 32'(drv), 0);

        // Corner pixel with grant already high.
        grant = 1'b1;
        @(posedge clk); #1;
        c0 = n_cpl;
        do_write(319, 239, 'hA5, 0, 0, lat, st);
        check("corner_latency", lat, 6);
        check("corner_strobe", st, 2);
        drop_req();
        repeat (4) @(posedge clk);
        #1;
        check("corner_cpl_count", n_cpl - c0, 1);
        check("corner_oor", 32'(oor), 0);

        // Grant withheld for 10 cycles, then revoked during STROBE.
        grant = 1'b0;
        do_write(0, 1, 'h3C, 10, 1, lat, st);
        check("grant_wait_latency", lat, 14);
        check("grant_wait_strobe", st, 2);
        drop_req();

        // Out-of-range requests retire in one cycle with no strobe.
        do_write(320, 0, 'h11, 0, 0, lat, st);
        check("oor_x_latency", lat, 1);
        check("oor_x_strobe", st, 0);
        drop_req();
        check("oor_set", 32'(oor), 1);
        do_write(0, 240, 'h22, 0, 0, lat, st);
        check("oor_y_latency", lat, 1);
        drop_req();
        do_write(5, 2, 'h77, 0, 0, lat, st);
        check("after_oor_latency", lat, 6);
        drop_req();
        check("oor_sticky", 32'(oor), 1);

        // Back-to-back raster stream: first and last two lines.
        @(posedge clk); #1;
        c0 = n_cpl;
        for (int p = 0; p < 76800; p++) begin
            if (p == 640) p = 76160;
            do_write(p % 320, p / 320, p & 255, 0, 0, lat, st);
            check("stream_period", lat, 6);
        end
        drop_req();
        repeat (3) @(posedge clk);
        #1;
        check("stream_cpl_count", n_cpl - c0, 1280);
        check("stream_sb_empty", sb.size(), 0);

        // Reset asserted in the middle of STROBE.
        @(posedge clk); #1;
        begin
            exp_t e;
            e.a = 17'(10 * 320 + 10);
            e.d = 8'h99;
            sb.push_back(e);
        end
        px = 9'd10; py = 8'd10; pd = 8'h99; req = 1'b1;
        st = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!wen) begin
                st = 1;
                break;
            end
        end
        check("reset_reached_strobe", st, 1);
        #2;
        rst = 1'b1; req = 1'b0;
        #1;
        check("reset_async_wen", 32'(wen), 1);
        check("reset_async_drv", 32'(drv), 0);
        check("reset_async_breq", 32'(breq), 0);
        c0 = n_cpl;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("reset_no_cpl", n_cpl - c0, 0);
        check("reset_oor_cleared", 32'(oor), 0);

        // Strobe-width sweep.
        sweep_write(0, lat, st);
        check("p1_strobe", st, 1);
        check("p1_latency", lat, 5);
        sweep_write(1, lat, st);
        check("p15_strobe", st, 15);
        check("p15_latency", lat, 19);
        check("sweep_oor", 32'({oor_a, oor_b}), 0);

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gfx_framebuffer_writer.md
# gfx_framebuffer_writer

Single-port framebuffer write engine sitting directly downstream of the GFX drawing units (clear-screen, pixel plot, fill). It accepts one pixel write at a time as (x, y, colour) over a level request / pulse complete handshake and converts the coordinate to a linear 17-bit framebuffer address. It arbitrates for the external SRAM bus with the video scan-out via request/grant, then runs a timed SRAM write cycle.

## Interface

- SCREEN_WIDTH, 320: pixels per line; address stride.
- SCREEN_HEIGHT, 240: lines per frame.
- WRITE_PULSE, 2: cycles sramWriteEnable_n is held low; legal range 1..15.

- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- writeRequest  in  1  level; upstream holds high with stable pixelX/pixelY/pixelData until writeComplete.
- pixelX  in  9  column, 0..SCREEN_WIDTH-1.
- pixelY  in  8  line, 0..SCREEN_HEIGHT-1.
- pixelData  in  8  colour byte to store.
- writeComplete  out  1  one-cycle pulse: the request has been retired (written or rejected).
- outOfRange  out  1  sticky; set when a request with pixelX >= SCREEN_WIDTH or pixelY >= SCREEN_HEIGHT is retired; cleared only by reset.
- busRequest  out  1  registered; writer wants or owns the SRAM bus.
- busGrant  in  1  from video arbiter; sampled only in IDLE.
- sramAddress  out  17  registered framebuffer address.
- sramWriteData  out  8  registered write data.
- sramDataDrive  out  1  tri-state enable for the SRAM data pins.
- sramWriteEnable_n  out  1  active-low SRAM write strobe.

## Operation

- Address = pixelY*SCREEN_WIDTH + pixelX, computed in 17 bits; for 320 it is (y<<8)+(y<<6)+x, max 76799. No overflow is possible for in-range coordinates.
- Range check is combinational on the inputs and evaluated in IDLE.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: busRequest = writeRequest & in-range (registered next cycle). If writeRequest & out-of-range: go to DONE without any SRAM activity and set outOfRange. If writeRequest & in-range & busGrant & busRequest: latch address/data into sramAddress/sramWriteData, go to SETUP.
- SETUP: sramDataDrive=1, sramWriteEnable_n=1 for one cycle (address/data setup); load strobe counter with WRITE_PULSE-1.
- STROBE: sramWriteEnable_n=0; decrement counter; leave to HOLD when counter is 0.
- HOLD: sramWriteEnable_n=1, sramDataDrive still 1, address/data unchanged (hold time); busRequest drops at the end of HOLD.
- DONE: writeComplete=1 for exactly one cycle, sramDataDrive=0; return to IDLE.
- busGrant deasserting during SETUP/STROBE/HOLD is ignored; the started cycle always completes, so the arbiter must not revoke grant while busRequest is high.
- writeRequest dropping mid-cycle is a protocol violation; the writer finishes the cycle regardless using the latched values.
- sramAddress/sramWriteData keep their last value in IDLE and DONE.
- Reset mid-cycle: sramWriteEnable_n returns high and sramDataDrive low asynchronously; the interrupted write is lost and no writeComplete is issued.

## Timing

- Reset values: writeComplete 0, outOfRange 0, busRequest 0, sramAddress 0, sramWriteData 0, sramDataDrive 0, sramWriteEnable_n 1; state IDLE.
- Let A be the IDLE cycle in which the write is accepted. SETUP is A+1, STROBE is A+2..A+1+WRITE_PULSE, HOLD is A+2+WRITE_PULSE, DONE (writeComplete high) is A+3+WRITE_PULSE.
- Minimum acceptance: a request first raised in cycle R gives busRequest high at R+1, so the earliest A is R+1 if busGrant is high.
- With WRITE_PULSE=2, complete is 6 cycles after the request is raised with grant already high.
- Out-of-range: request in IDLE at cycle R gives DONE at R+1; outOfRange rises at R+1 and stays high.
- Back-to-back: upstream updates inputs on the edge that ends DONE; the next IDLE samples the new request, so throughput is one pixel per 5+WRITE_PULSE cycles.
- No double write: the writer never accepts in DONE.

## Test plan

- Reset then idle: check every output equals its reset value. Assert reset in STROBE with WRITE_PULSE=2: sramWriteEnable_n=1 and sramDataDrive=0 immediately, and no writeComplete follows.
- Write (x=319, y=239, data=0xA5) with busGrant=1: sramAddress=76799, sramWriteData=0xA5, sramWriteEnable_n low for exactly 2 cycles, writeComplete 6 cycles after the request rises, no other writeComplete.
- Write (0,1,0x3C) with busGrant=0 for 10 cycles, then 1: busRequest high throughout, no strobe until grant, address=320; drop busGrant during STROBE and the cycle still completes.
- Request (x=320, y=0): writeComplete 1 cycle later, no strobe, outOfRange=1 and still 1 after a following valid write.
- Drive the clear-screen stream of 76800 sequential pixels with busGrant=1: 76800 writeComplete pulses, addresses 0..76799 in order with no gaps or duplicates, 7 cycles per pixel.
- Parameter sweep WRITE_PULSE=1 and 15: strobe width equals the parameter, and completion latency equals 3+WRITE_PULSE after acceptance.
